// File: rtl/flash_boot_loader.sv
// flash_boot_loader: one SPI READ (0x03) burst from flash, packed LANES bytes per word into code RAM.
// Define FLASH_BOOT_CKSUM_EN to read a trailing big-endian 16-bit byte sum and flag a mismatch.
module flash_boot_loader #(
  parameter int FLASH_ADDR_W = 24,
  parameter int RAM_ADDR_W   = 19,
  parameter int LANES        = 4,
  parameter int SCK_DIV      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [FLASH_ADDR_W-1:0] flash_addr_i,
  input  logic [RAM_ADDR_W:0]     num_words_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    cksum_err_o,
  output logic                    cs_n_o,
  output logic                    sck_o,
  output logic                    mosi_o,
  input  logic                    miso_i,
  output logic [RAM_ADDR_W-1:0]   ram_addr_o,
  output logic [LANES-1:0]        ram_wen_o,
  output logic [8*LANES-1:0]      ram_din_o
);
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, WRITE,
`ifdef FLASH_BOOT_CKSUM_EN
    CKSUM,
`endif
    TAIL, FINISH
  } state_t;
`ifdef FLASH_BOOT_CKSUM_EN
  localparam state_t LAST = CKSUM;
`else
  localparam state_t LAST = TAIL;
`endif
  localparam int TX_W  = FLASH_ADDR_W + 8;
  localparam int CNT_W = $clog2(SCK_DIV + 1);
  localparam int NW_W  = RAM_ADDR_W + 1;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sck_q, sck_d;
  logic [TX_W-1:0]       tx_q, tx_d;
  logic [7:0]            bit_q, bit_d, bit_in;
  logic [6:0]            byte_q, byte_d;
  logic [8*LANES-1:0]    data_q, data_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [NW_W-1:0]       words_q, words_d;
  logic                  active, tick, rise, fall;
  int                    lane;
`ifdef FLASH_BOOT_CKSUM_EN
  logic [15:0] sum_q, sum_d, exp_q, exp_d;
  logic        err_q, err_d;
  assign cksum_err_o = err_q;
`else
  assign cksum_err_o = 1'b0;
`endif
  assign active     = !(state_q inside {IDLE, FINISH});
  assign tick       = active && cnt_q == CNT_W'(SCK_DIV - 1);
  assign rise       = tick && !sck_q;
  assign fall       = tick && sck_q;
  assign bit_in     = {byte_q, miso_i};
  assign lane       = int'(bit_q[5:3]);
  assign busy_o     = active;
  assign cs_n_o     = !active;
  assign done_o     = state_q == FINISH;
  assign sck_o      = sck_q;
  assign mosi_o     = active && tx_q[TX_W-1];
  assign ram_wen_o  = {LANES{state_q == WRITE}};
  assign ram_addr_o = addr_q;
  assign ram_din_o  = data_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = active ? (tick ? '0 : cnt_q + 1'b1) : '0;
    // the rise that would follow the last bit is swallowed: it times cs_n release
    sck_d   = fall ? 1'b0 : (rise && state_q != TAIL) ? 1'b1 : sck_q;
    tx_d    = fall ? {tx_q[TX_W-2:0], 1'b0} : tx_q;
    bit_d   = rise ? bit_q + 8'd1 : bit_q;
    byte_d  = rise ? bit_in[6:0] : byte_q;
    data_d  = data_q;
    addr_d  = addr_q;
    words_d = words_q;
`ifdef FLASH_BOOT_CKSUM_EN
    sum_d   = sum_q;
    exp_d   = exp_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        state_d = num_words_i == '0 ? FINISH : CMD;
        tx_d    = {8'h03, flash_addr_i};
        words_d = num_words_i;
        addr_d  = '0;
        bit_d   = '0;
`ifdef FLASH_BOOT_CKSUM_EN
        sum_d   = '0;
        err_d   = 1'b0;
`endif
      end
      CMD: if (rise && bit_q == 8'd7) begin
        state_d = ADDR;
        bit_d   = '0;
      end
      ADDR: if (rise && bit_q == 8'(FLASH_ADDR_W - 1)) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (rise) begin
        if (bit_q[2:0] == 3'd7) begin
          data_d[8*lane +: 8] = bit_in;
`ifdef FLASH_BOOT_CKSUM_EN
          sum_d = sum_q + 16'(bit_in);
`endif
        end
        if (bit_q == 8'(8*LANES - 1)) begin
          state_d = WRITE;
          bit_d   = '0;
        end
      end
      WRITE: begin
        state_d = words_q == NW_W'(1) ? LAST : DATA;
        addr_d  = addr_q + 1'b1;
        words_d = words_q - 1'b1;
      end
`ifdef FLASH_BOOT_CKSUM_EN
      CKSUM: if (rise) begin
        exp_d = {exp_q[14:0], miso_i};
        if (bit_q == 8'd15) begin
          state_d = TAIL;
          bit_d   = '0;
        end
      end
`endif
      TAIL: if (rise) begin
        state_d = FINISH;
`ifdef FLASH_BOOT_CKSUM_EN
        err_d   = exp_q != sum_q;
`endif
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      tx_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
`ifdef FLASH_BOOT_CKSUM_EN
      sum_q   <= '0;
      exp_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      tx_q    <= tx_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      words_q <= words_d;
`ifdef FLASH_BOOT_CKSUM_EN
      sum_q   <= sum_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: two instances (default, and RAM_ADDR_W=2/SCK_DIV=1) share one flash model.
module tb_flash_boot_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
`ifdef FLASH_BOOT_CKSUM_EN
  localparam int RISES1 = 80;
`else
  localparam int RISES1 = 64;
`endif
  logic rst_n, miso, sel;
  logic a_start, b_start;
  logic [23:0] a_fa, b_fa;
  logic [19:0] a_nw;
  logic [2:0]  b_nw;
  logic a_busy, a_done, a_err, a_cs, a_sck, a_mosi;
  logic b_busy, b_done, b_err, b_cs, b_sck, b_mosi;
  logic [18:0] a_ra;
  logic [1:0]  b_ra;
  logic [3:0]  a_wen, b_wen;
  logic [31:0] a_din, b_din;
  logic m_cs, m_sck, m_mosi, m_done, m_busy;
  logic [3:0]  m_wen;
  logic [18:0] m_ra;
  logic [31:0] m_din;
  flash_boot_loader u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .flash_addr_i(a_fa), .num_words_i(a_nw),
    .busy_o(a_busy), .done_o(a_done), .cksum_err_o(a_err), .cs_n_o(a_cs), .sck_o(a_sck),
    .mosi_o(a_mosi), .miso_i(miso), .ram_addr_o(a_ra), .ram_wen_o(a_wen), .ram_din_o(a_din));
  flash_boot_loader #(.RAM_ADDR_W(2), .SCK_DIV(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .flash_addr_i(b_fa), .num_words_i(b_nw),
    .busy_o(b_busy), .done_o(b_done), .cksum_err_o(b_err), .cs_n_o(b_cs), .sck_o(b_sck),
    .mosi_o(b_mosi), .miso_i(miso), .ram_addr_o(b_ra), .ram_wen_o(b_wen), .ram_din_o(b_din));
  assign m_cs   = sel ? b_cs : a_cs;
  assign m_sck  = sel ? b_sck : a_sck;
  assign m_mosi = sel ? b_mosi : a_mosi;
  assign m_done = sel ? b_done : a_done;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_wen  = sel ? b_wen : a_wen;
  assign m_ra   = sel ? {17'd0, b_ra} : a_ra;
  assign m_din  = sel ? b_din : a_din;
  int checks = 0, failures = 0, writes = 0, done_cnt = 0, rises = 0;
  logic cs_low_seen = 1'b0;
  logic [31:0] mosi_sr = '0;
  logic [7:0] mem [0:63];
  logic [50:0] sb [$];
  logic [50:0] ent;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  always @(negedge m_cs) begin
    rises = 0;
    mosi_sr = '0;
  end
  always @(posedge m_sck) if (!m_cs) begin
    if (rises < 32) mosi_sr = {mosi_sr[30:0], m_mosi};
    rises++;
  end
  always @(negedge m_sck) if (!m_cs && rises >= 32 && rises < 32 + 64*8)
    miso = mem[(rises-32)/8][7-((rises-32)%8)];
  always @(negedge clk) begin
    if (!m_cs) cs_low_seen = 1'b1;
    if (m_done) done_cnt++;
    if (m_wen != '0) begin
      writes++;
      check("wen_mask", 64'(m_wen), 64'hF);
      check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        ent = sb.pop_front();
        check("ram_addr", 64'(m_ra), 64'(ent[50:32]));
        check("ram_din", 64'(m_din), 64'(ent[31:0]));
      end
    end
  end
  task automatic go(input logic s, input logic [23:0] fa, input int nw);
    @(negedge clk);
    sel = s;
    if (s) begin b_fa = fa; b_nw = 3'(nw); b_start = 1'b1; end
    else begin a_fa = fa; a_nw = 20'(nw); a_start = 1'b1; end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask
  task automatic wait_done(output int gaps);
    gaps = 0;
    for (int i = 0; i < 4000 && !m_done; i++) begin
      if (!m_busy) gaps++;
      @(negedge clk);
    end
    check("done_timeout", 64'(m_done), 64'd1);
  endtask
  task automatic push_words(input int n, input int wrap);
    for (int k = 0; k < n; k++)
      sb.push_back({19'(k % wrap), mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    int g, w0, d0;
    rst_n = 1'b0; miso = 1'b0; sel = 1'b0;
    a_start = 1'b0; b_start = 1'b0; a_fa = '0; b_fa = '0; a_nw = '0; b_nw = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 64'(a_cs), 64'd1);
    check("rst_sck", 64'(a_sck), 64'd0);
    check("rst_mosi", 64'(a_mosi), 64'd0);
    check("rst_busy_done_err", 64'({a_busy, a_done, a_err}), 64'd0);
    check("rst_ram", 64'({a_wen, a_ra}), 64'd0);
    check("rst_din", 64'(a_din), 64'd0);
    rst_n = 1'b1;
    // single word, default timing
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h00; mem[5] = 8'hAA;
    push_words(1, 1 << 19);
    w0 = writes; d0 = done_cnt;
    go(1'b0, 24'h000100, 1);
    check("t1_busy", 64'(a_busy), 64'd1);
    check("t1_cs_low", 64'(a_cs), 64'd0);
    check("t1_first_mosi", 64'(a_mosi), 64'd0);
    wait_done(g);
    check("t1_done_busy", 64'(a_busy), 64'd0);
    check("t1_done_cs_n", 64'(a_cs), 64'd1);
    check("t1_done_sck", 64'(a_sck), 64'd0);
    check("t1_sck_rises", 64'(rises), 64'(RISES1));
    check("t1_mosi_bits", 64'(mosi_sr), 64'h03000100);
    check("t1_cksum_err", 64'(a_err), 64'd0);
    check("t1_gaps", 64'(g), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(a_done), 64'd0);
    repeat (5) @(negedge clk);
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);
    check("t1_writes", 64'(writes - w0), 64'd1);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    // three words, SCK_DIV=1
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    push_words(3, 4);
    w0 = writes;
    go(1'b1, 24'h000000, 3);
    wait_done(g);
    check("t2_busy_gaps", 64'(g), 64'd0);
    check("t2_done_busy", 64'(b_busy), 64'd0);
    check("t2_mosi_bits", 64'(mosi_sr), 64'h03000000);
    repeat (5) @(negedge clk);
    check("t2_writes", 64'(writes - w0), 64'd3);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);
    // zero words
    cs_low_seen = 1'b0;
    w0 = writes;
    go(1'b0, 24'h123456, 0);
    check("t3_done", 64'(a_done), 64'd1);
    check("t3_cs_n", 64'(a_cs), 64'd1);
    check("t3_busy", 64'(a_busy), 64'd0);
    repeat (10) @(negedge clk);
    check("t3_cs_never_low", 64'(cs_low_seen), 64'd0);
    check("t3_writes", 64'(writes - w0), 64'd0);
    // start re-pulsed mid-DATA
    for (int i = 0; i < 64; i++) mem[i] = 8'hA0 + 8'(i);
    push_words(2, 1 << 19);
    w0 = writes;
    go(1'b0, 24'h000200, 2);
    repeat (140) @(negedge clk);
    check("t4_busy_mid", 64'(a_busy), 64'd1);
    a_fa = 24'hABCDEF; a_nw = 20'd5; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_done(g);
    check("t4_mosi_bits", 64'(mosi_sr), 64'h03000200);
    repeat (5) @(negedge clk);
    check("t4_writes", 64'(writes - w0), 64'd2);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);
    // reset during ADDR
    w0 = writes; d0 = done_cnt;
    go(1'b0, 24'h000300, 1);
    repeat (60) @(negedge clk);
    check("t5_busy_pre", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_cs_n", 64'(a_cs), 64'd1);
    check("t5_sck", 64'(a_sck), 64'd0);
    check("t5_busy", 64'(a_busy), 64'd0);
    check("t5_wen_mosi", 64'({a_wen, a_mosi}), 64'd0);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("t5_no_write", 64'(writes - w0), 64'd0);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    // RAM address wrap at 2^2
    for (int i = 0; i < 64; i++) mem[i] = 8'h40 + 8'(i);
    push_words(5, 4);
    w0 = writes;
    go(1'b1, 24'h000000, 5);
    wait_done(g);
    repeat (5) @(negedge clk);
    check("t6_writes", 64'(writes - w0), 64'd5);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);
`ifdef FLASH_BOOT_CKSUM_EN
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h00; mem[5] = 8'hAA;
    push_words(1, 1 << 19);
    go(1'b0, 24'h000100, 1);
    wait_done(g);
    check("t7_err_good", 64'(a_err), 64'd0);
    mem[5] = 8'hAB;
    push_words(1, 1 << 19);
    go(1'b0, 24'h000100, 1);
    wait_done(g);
    check("t7_err_bad", 64'(a_err), 64'd1);
    @(negedge clk);
    check("t7_err_hold", 64'(a_err), 64'd1);
    go(1'b0, 24'h000000, 0);
    check("t7_err_clear", 64'(a_err), 64'd0);
    repeat (3) @(negedge clk);
    check("t7_sb_empty", 64'(sb.size()), 64'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
